tone_generator: RTL
===================

# tone_generator

Converts the note/octave selection produced by the piano controller into a square wave for the board buzzer/audio amplifier. Sits directly downstream of the controller: it consumes `note_out` and `octave_out` (wired to `note_in` and `octave_in`) and drives the audio pin. A programmable articulation gap separates consecutive different notes so that note changes are audible.

## Interface
- `GAP_CYCLES`, default 2_000_000: silent cycles inserted between two different sounding notes (20 ms at 100 MHz). A value of 0 disables the gap.
- `clk`  in  1  system clock, 100 MHz.
- `reset`  in  1  synchronous, active-high reset.
- `enable`  in  1  when 0, the target is forced silent.
- `note_in`  in  4  0 = rest; 1..7 = do re mi fa sol la si; 8..15 are treated as rest.
- `octave_in`  in  2  00 low, 01 middle, 10 high, 11 treated as middle.
- `speaker`  out  1  square-wave audio output.
- `aud_sd`  out  1  amplifier enable; 1 only in TONE.
- `playing`  out  1  1 only in TONE.
- `note_playing`  out  4  latched note currently sounding; 0 when not in TONE.

## Operation
- Target each cycle:
  - Silent if `enable` = 0 or `note_in` is not in 1..7.
  - Otherwise the pair {`note_in`, `octave_in` with 11 mapped to 01}.
- Middle-octave half-period table, in cycles (floor of 1e8 / (2·f)):
  - 1 → 191109
  - 2 → 170265
  - 3 → 151685
  - 4 → 143172
  - 5 → 127551
  - 6 → 113636
  - 7 → 101239
- Octave scaling:
  - Low: half-period shifted left by 1.
  - High: half-period shifted right by 1 (floor).
  - Maximum value is 382218, so the half-period and tone counter are 19 bits.
  - The gap counter is sized by `$clog2(GAP_CYCLES+1)`, minimum 1 bit.
- State machine: IDLE, TONE, GAP.
  - IDLE:
    - `speaker` = 0 and counters = 0.
    - Sounding target → latch target and half-period, set cnt = 0 and `speaker` = 0, go to TONE.
  - TONE:
    - If cnt == half−1: toggle `speaker` and set cnt = 0; else cnt++.
    - Silent target → IDLE, `speaker` = 0.
    - Sounding target different from the latched pair:
      - If `GAP_CYCLES` > 0: go to GAP with gap_cnt = 0 and `speaker` = 0.
      - If `GAP_CYCLES` = 0: reload the new pair, set cnt = 0 and `speaker` = 0, stay in TONE.
    - Target equal to the latched pair → continue counting.
  - GAP:
    - `speaker` = 0; gap_cnt increments each cycle.
    - Silent target at any point → IDLE immediately.
    - Target changes during GAP are ignored until the end of the gap.
    - At gap_cnt == GAP_CYCLES−1: the current target is latched (cnt = 0), go to TONE.
- Exit priority in TONE/GAP: reset > silent target > change > count.
- Reset from any state:
  - State goes to IDLE.
  - `speaker`, `aud_sd` and `playing` go to 0; `note_playing` goes to 0.
  - All counters go to 0.
  - Output takes effect at the first clock edge with `reset` = 1.

## Timing
- All outputs are registered.
- Entry from IDLE:
  - If the target becomes sounding before edge k, then after edge k: state = TONE, `playing` = 1, `aud_sd` = 1, `speaker` = 0.
  - The first rising edge of `speaker` occurs at edge k+half.
  - Steady period is 2·half cycles at exactly 50% duty.
- Exit: a silent target before edge k gives `speaker` = `playing` = `aud_sd` = 0 after edge k (1-cycle latency).
- Note change with a gap:
  - Change detected at edge k → GAP after k.
  - TONE after edge k+GAP_CYCLES.
  - First `speaker` rise at edge k+GAP_CYCLES+half_new.
- Octave-only change counts as a note change.
- A 1-cycle glitch in `note_in` during TONE still triggers a full gap.

## Test plan
- Reset, then `note_in` = 6, `octave_in` = 01, `enable` = 1 → `playing` = 1 one cycle later; `speaker` toggles every 113636 cycles, period 227272.
- `note_in` = 1 with `octave_in` = 00, then 10 → half-periods of 382218 and 95554 cycles respectively; `octave_in` = 11 → 191109.
- TONE on 3/01, switch to 5/01 with `GAP_CYCLES` = 1000 → `speaker` = 0 for 1000 cycles, TONE resumes, first rise 127551 cycles later; with `GAP_CYCLES` = 0 → immediate reload, no silent gap.
- `note_in` = 9, or `enable` = 0 during TONE → IDLE next cycle with all outputs 0; `note_in` = 0 in the middle of GAP → IDLE the next cycle.
- Assert `reset` in the middle of a tone with `speaker` = 1 → after that edge all outputs are 0; deassert with a sounding target → normal entry timing.
- Change the target to 2/01 and back to 4/01 during GAP → the pair sampled at the end of the gap (4/01) is played; `note_playing` = 4.

Source files
------------

// File: rtl/tone_generator_if.sv
// Note/octave selection toward the tone generator and its audio outputs back.
// The controller side uses master, the generator uses slave.
interface tone_if;
    logic       enable;
    logic [3:0] note_in;
    logic [1:0] octave_in;
    logic       speaker;
    logic       aud_sd;
    logic       playing;
    logic [3:0] note_playing;

    modport master (
        output enable, note_in, octave_in,
        input  speaker, aud_sd, playing, note_playing
    );

    modport slave (
        input  enable, note_in, octave_in,
        output speaker, aud_sd, playing, note_playing
    );
endinterface

// File: rtl/tone_generator.sv
// Square-wave generator for the selected note/octave with a silent gap between notes.
// All outputs registered; one cycle from target change to output change.
module tone_generator #(
    parameter int GAP_CYCLES = 2_000_000
) (
    input  logic  clk,
    input  logic  reset,
    tone_if.slave tone
);
    localparam int GW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
    localparam logic [GW-1:0] GAP_LAST = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_TONE = 2'd1;
    localparam logic [1:0] S_GAP  = 2'd2;

    logic [1:0]    r_state;
    logic [3:0]    r_note;
    logic [1:0]    r_oct;
    logic [18:0]   r_half;
    logic [18:0]   r_cnt;
    logic [GW-1:0] r_gap_cnt;
    logic          r_speaker;
    logic          r_playing;
    logic [3:0]    r_note_playing;

    logic          w_sounding;
    logic [1:0]    w_oct;
    logic [18:0]   w_base;
    logic [18:0]   w_half;
    logic          w_change;

    assign w_sounding = tone.enable && (tone.note_in >= 4'd1) && (tone.note_in <= 4'd7);
    assign w_oct      = (tone.octave_in == 2'b11) ? 2'b01 : tone.octave_in;
    assign w_change   = {tone.note_in, w_oct} != {r_note, r_oct};

    // Middle-octave half periods: floor(1e8 / (2*f))
    always_comb begin
        w_base = 19'd0;
        case (tone.note_in)
            4'd1:    w_base = 19'd191109;
            4'd2:    w_base = 19'd170265;
            4'd3:    w_base = 19'd151685;
            4'd4:    w_base = 19'd143172;
            4'd5:    w_base = 19'd127551;
            4'd6:    w_base = 19'd113636;
            4'd7:    w_base = 19'd101239;
            default: w_base = 19'd0;
        endcase
    end

    always_comb begin
        w_half = w_base;
        case (w_oct)
            2'b00:   w_half = {w_base[17:0], 1'b0};
            2'b10:   w_half = {1'b0, w_base[18:1]};
            default: w_half = w_base;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state        <= S_IDLE;
            r_note         <= 4'd0;
            r_oct          <= 2'd0;
            r_half         <= 19'd0;
            r_cnt          <= 19'd0;
            r_gap_cnt      <= '0;
            r_speaker      <= 1'b0;
            r_playing      <= 1'b0;
            r_note_playing <= 4'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_speaker <= 1'b0;
                    r_cnt     <= 19'd0;
                    r_gap_cnt <= '0;
                    if (w_sounding) begin
                        r_note         <= tone.note_in;
                        r_oct          <= w_oct;
                        r_half         <= w_half;
                        r_state        <= S_TONE;
                        r_playing      <= 1'b1;
                        r_note_playing <= tone.note_in;
                    end
                end
                S_TONE: begin
                    if (!w_sounding) begin
                        r_state        <= S_IDLE;
                        r_speaker      <= 1'b0;
                        r_cnt          <= 19'd0;
                        r_playing      <= 1'b0;
                        r_note_playing <= 4'd0;
                    end else if (w_change) begin
                        r_speaker <= 1'b0;
                        r_cnt     <= 19'd0;
                        if (GAP_CYCLES > 0) begin
                            r_state        <= S_GAP;
                            r_gap_cnt      <= '0;
                            r_playing      <= 1'b0;
                            r_note_playing <= 4'd0;
                        end else begin
                            r_note         <= tone.note_in;
                            r_oct          <= w_oct;
                            r_half         <= w_half;
                            r_note_playing <= tone.note_in;
                        end
                    end else if (r_cnt == r_half - 19'd1) begin
                        r_speaker <= ~r_speaker;
                        r_cnt     <= 19'd0;
                    end else begin
                        r_cnt <= r_cnt + 19'd1;
                    end
                end
                S_GAP: begin
                    r_speaker <= 1'b0;
                    if (!w_sounding) begin
                        r_state   <= S_IDLE;
                        r_gap_cnt <= '0;
                    end else if (r_gap_cnt == GAP_LAST) begin
                        // Whatever is selected when the gap expires is what plays next
                        r_note         <= tone.note_in;
                        r_oct          <= w_oct;
                        r_half         <= w_half;
                        r_cnt          <= 19'd0;
                        r_gap_cnt      <= '0;
                        r_state        <= S_TONE;
                        r_playing      <= 1'b1;
                        r_note_playing <= tone.note_in;
                    end else begin
                        r_gap_cnt <= r_gap_cnt + GW'(1);
                    end
                end
                default: begin
                    r_state        <= S_IDLE;
                    r_speaker      <= 1'b0;
                    r_playing      <= 1'b0;
                    r_note_playing <= 4'd0;
                end
            endcase
        end
    end

    assign tone.speaker      = r_speaker;
    assign tone.aud_sd       = r_playing;
    assign tone.playing      = r_playing;
    assign tone.note_playing = r_note_playing;
endmodule
